// File: rtl/apb_master_queued.sv
// APB4 master fed by a command FIFO: decodes the slave from the top address bits,
// runs commands back-to-back and returns one in-order response per command.
module apb_master_queued #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int SLAVES_NUM     = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic                          IN_WRITE,
    input  logic [ADDRESS_WIDTH-1:0]      IN_ADDR,
    input  logic [DATA_WIDTH-1:0]         IN_DATA,
    input  logic [STRB_WIDTH-1:0]         IN_STRB,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OUT_VALID,
    output logic [DATA_WIDTH-1:0]         OUT_RDATA,
    output logic                          OUT_SLVERR,
    output logic                          OUT_TIMEOUT,
    output logic [ADDRESS_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    output logic                          PWRITE,
    output logic [STRB_WIDTH-1:0]         PSTRB,
    output logic [SLAVES_NUM-1:0]         PSEL,
    output logic                          PENABLE,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int SEL_BITS = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        logic                     write;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        logic [STRB_WIDTH-1:0]    strb;
    } cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    // ---------------- command FIFO ----------------
    cmd_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic              push, pop;
    cmd_t              head;

    assign push       = IN_VALID && IN_READY;
    assign head       = mem[rd_ptr];
    assign level_next = FIFO_LEVEL + LVL_W'(push) - LVL_W'(pop);

    // NOTE: storage array has no reset; entries are only read once the level says they were written.
    always_ff @(posedge PCLK) begin
        if (push)
            mem[wr_ptr] <= '{write: IN_WRITE, addr: IN_ADDR, data: IN_DATA, strb: IN_STRB};
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
            IN_READY   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            FIFO_LEVEL <= level_next;
            IN_READY   <= (level_next != LVL_W'(FIFO_DEPTH));
        end
    end

    // Slave decode of the command at the FIFO head
    logic [SEL_BITS-1:0]   head_idx;
    logic                  head_err;
    logic [SLAVES_NUM-1:0] head_psel;

    assign head_idx  = head.addr[ADDRESS_WIDTH-1 -: SEL_BITS];
    assign head_err  = (int'(head_idx) >= SLAVES_NUM);
    assign head_psel = SLAVES_NUM'(1) << head_idx;

    // ---------------- transfer FSM ----------------
    state_t                state, state_next;
    logic [CNT_W-1:0]      wait_cnt, wait_next;
    logic [SLAVES_NUM-1:0] psel_next;
    logic                  penable_next, pwrite_next;
    logic [ADDRESS_WIDTH-1:0] paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_next, rdata_next;
    logic [STRB_WIDTH-1:0] pstrb_next;
    logic                  valid_next, slverr_next, timeout_next;
    logic                  has_cmd, timed_out;

    assign has_cmd   = (FIFO_LEVEL != '0);
    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        pop          = 1'b0;
        psel_next    = PSEL;
        penable_next = 1'b0;
        paddr_next   = PADDR;
        pwdata_next  = PWDATA;
        pwrite_next  = PWRITE;
        pstrb_next   = PSTRB;
        valid_next   = 1'b0;
        rdata_next   = '0;
        slverr_next  = 1'b0;
        timeout_next = 1'b0;

        unique case (state)
            ST_IDLE: begin
                psel_next = '0;
                if (has_cmd) begin
                    pop = 1'b1;
                    if (head_err) begin
                        valid_next  = 1'b1;
                        slverr_next = 1'b1;
                    end else begin
                        psel_next   = head_psel;
                        paddr_next  = head.addr;
                        pwdata_next = head.data;
                        pwrite_next = head.write;
                        pstrb_next  = head.write ? head.strb : '0;
                        state_next  = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                penable_next = 1'b1;
                wait_next    = '0;
                state_next   = ST_ACCESS;
            end
            ST_ACCESS: begin
                penable_next = 1'b1;
                if (PREADY) begin
                    penable_next = 1'b0;
                    valid_next   = 1'b1;
                    rdata_next   = PWRITE ? '0 : PRDATA;
                    slverr_next  = PSLVERR;
                    // A decode-error head is left for IDLE so two responses never collide.
                    if (has_cmd && !head_err) begin
                        pop         = 1'b1;
                        psel_next   = head_psel;
                        paddr_next  = head.addr;
                        pwdata_next = head.data;
                        pwrite_next = head.write;
                        pstrb_next  = head.write ? head.strb : '0;
                        state_next  = ST_SETUP;
                    end else begin
                        psel_next  = '0;
                        state_next = ST_IDLE;
                    end
                end else if (timed_out) begin
                    penable_next = 1'b0;
                    psel_next    = '0;
                    valid_next   = 1'b1;
                    slverr_next  = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_next = wait_cnt + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            PSTRB       <= '0;
            OUT_VALID   <= 1'b0;
            OUT_RDATA   <= '0;
            OUT_SLVERR  <= 1'b0;
            OUT_TIMEOUT <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            PSEL        <= psel_next;
            PENABLE     <= penable_next;
            PADDR       <= paddr_next;
            PWDATA      <= pwdata_next;
            PWRITE      <= pwrite_next;
            PSTRB       <= pstrb_next;
            OUT_VALID   <= valid_next;
            OUT_RDATA   <= rdata_next;
            OUT_SLVERR  <= slverr_next;
            OUT_TIMEOUT <= timeout_next;
        end
    end

endmodule

// File: tb/tb_apb_master_queued.sv
// Directed bench for apb_master_queued: a reactive APB slave checks each transfer,
// a response monitor checks each OUT_VALID pulse against a queue of expected responses.
module tb_apb_master_queued;

    logic        PCLK, PRESET;
    logic        IN_VALID, IN_READY, IN_WRITE;
    logic [3:0]  IN_ADDR, IN_STRB;
    logic [31:0] IN_DATA;
    logic [2:0]  FIFO_LEVEL;
    logic        OUT_VALID, OUT_SLVERR, OUT_TIMEOUT;
    logic [31:0] OUT_RDATA;
    logic [3:0]  PADDR, PSTRB;
    logic [31:0] PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PREADY, PSLVERR;
    logic [1:0]  PSEL;

    apb_master_queued #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(4), .STRB_WIDTH(4),
        .SLAVES_NUM(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_WRITE(IN_WRITE),
        .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA), .IN_STRB(IN_STRB),
        .FIFO_LEVEL(FIFO_LEVEL),
        .OUT_VALID(OUT_VALID), .OUT_RDATA(OUT_RDATA), .OUT_SLVERR(OUT_SLVERR), .OUT_TIMEOUT(OUT_TIMEOUT),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB),
        .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [1:0]  psel;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        wr;
        logic [3:0]  strb;
        int          wt;
        logic [31:0] rdata;
        logic        err;
    } apb_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        timeout;
    } rsp_exp_t;

    apb_exp_t apb_q[$];
    rsp_exp_t rsp_q[$];
    int       setup_hist[$];
    int       en_hist[$];
    int       total = 0;
    int       bad   = 0;
    int       cyc   = 0;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    task automatic expect_apb(input logic [1:0] psel, input logic [3:0] addr, input logic [31:0] wdata,
                              input logic wr, input logic [3:0] strb, input int wt,
                              input logic [31:0] rdata, input logic err);
        apb_exp_t e;
        e.psel = psel; e.addr = addr; e.wdata = wdata; e.wr = wr; e.strb = strb;
        e.wt = wt; e.rdata = rdata; e.err = err;
        apb_q.push_back(e);
    endtask

    task automatic expect_rsp(input logic [31:0] rdata, input logic slverr, input logic timeout);
        rsp_exp_t e;
        e.rdata = rdata; e.slverr = slverr; e.timeout = timeout;
        rsp_q.push_back(e);
    endtask

    // Drives one command; returns the cycle number of the accepting edge.
    task automatic send(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int push_cyc);
        int t = 0;
        @(negedge PCLK);
        IN_VALID = 1'b1; IN_WRITE = wr; IN_ADDR = addr; IN_DATA = data; IN_STRB = strb;
        while (!IN_READY && t < 200) begin
            @(negedge PCLK);
            t++;
        end
        check("send_accept_bound", 64'(t < 200), 64'd1);
        @(posedge PCLK);
        #1;
        push_cyc = cyc;
        IN_VALID = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0 || PSEL != 2'b00 || FIFO_LEVEL != 3'd0) && t < 500) begin
            @(negedge PCLK);
            t++;
        end
        check({tag, "_drain_bound"}, 64'(t < 500), 64'd1);
        repeat (3) @(negedge PCLK);
    endtask

    // Reactive APB slave plus transfer checker
    initial begin
        apb_exp_t cur;
        bit       have_cur = 0;
        int       acc_n = 0;
        int       en_run = 0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                have_cur = 0; acc_n = 0; en_run = 0;
                PREADY = 1'b0;
            end else begin
                if (PENABLE) en_run++;
                else if (en_run != 0) begin
                    en_hist.push_back(en_run);
                    en_run = 0;
                end
                if (PSEL != 2'b00 && !PENABLE) begin
                    setup_hist.push_back(cyc);
                    acc_n  = 0;
                    PREADY = 1'b0;
                    if (apb_q.size() == 0) begin
                        have_cur = 0;
                        flag("apb_setup_unexpected");
                    end else begin
                        cur = apb_q.pop_front();
                        have_cur = 1;
                        check("apb_setup", 64'({PSEL, PADDR, PWDATA, PWRITE, PSTRB}),
                              64'({cur.psel, cur.addr, cur.wdata, cur.wr, cur.strb}));
                    end
                end else if (PSEL != 2'b00 && PENABLE) begin
                    acc_n++;
                    if (have_cur) begin
                        check("apb_access_stable", 64'({PSEL, PADDR, PWDATA, PWRITE, PSTRB}),
                              64'({cur.psel, cur.addr, cur.wdata, cur.wr, cur.strb}));
                        PREADY  = (acc_n == cur.wt + 1);
                        PRDATA  = cur.rdata;
                        PSLVERR = cur.err;
                    end else begin
                        PREADY = 1'b1;
                    end
                end else begin
                    PREADY = 1'b0;
                end
            end
        end
    end

    // Response monitor
    initial begin
        rsp_exp_t e;
        forever begin
            @(negedge PCLK);
            if (OUT_VALID) begin
                if (rsp_q.size() == 0) begin
                    flag("rsp_unexpected");
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_rdata", 64'(OUT_RDATA), 64'(e.rdata));
                    check("rsp_slverr", 64'(OUT_SLVERR), 64'(e.slverr));
                    check("rsp_timeout", 64'(OUT_TIMEOUT), 64'(e.timeout));
                end
            end
        end
    end

    initial begin
        int pc, pc2;
        int t;
        IN_VALID = 1'b0; IN_WRITE = 1'b0; IN_ADDR = '0; IN_DATA = '0; IN_STRB = '0;
        PRESET = 1'b0;
        #2 PRESET = 1'b1;
        #1;
        check("reset_psel", 64'(PSEL), 64'd0);
        check("reset_penable", 64'(PENABLE), 64'd0);
        check("reset_out_valid", 64'(OUT_VALID), 64'd0);
        check("reset_level", 64'(FIFO_LEVEL), 64'd0);
        check("reset_in_ready", 64'(IN_READY), 64'd0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        check("post_reset_in_ready", 64'(IN_READY), 64'd1);

        // Single zero-wait write to slave 1
        setup_hist.delete(); en_hist.delete();
        expect_apb(2'b10, 4'hF, 32'd240, 1'b1, 4'b0101, 0, 32'd0, 1'b0);
        expect_rsp(32'd0, 1'b0, 1'b0);
        send(1'b1, 4'hF, 32'd240, 4'b0101, pc);
        drain("write0");
        check("write0_setup_latency", 64'(setup_hist[0]), 64'(pc + 1));
        check("write0_penable_len", 64'(en_hist[0]), 64'd1);

        // Two queued writes run back-to-back
        setup_hist.delete(); en_hist.delete();
        expect_apb(2'b10, 4'hF, 32'd240, 1'b1, 4'hF, 0, 32'd0, 1'b0);
        expect_apb(2'b01, 4'h1, 32'd15,  1'b1, 4'hF, 0, 32'd0, 1'b0);
        expect_rsp(32'd0, 1'b0, 1'b0);
        expect_rsp(32'd0, 1'b0, 1'b0);
        send(1'b1, 4'hF, 32'd240, 4'hF, pc);
        send(1'b1, 4'h1, 32'd15,  4'hF, pc2);
        drain("b2b");
        check("b2b_setup_count", 64'(setup_hist.size()), 64'd2);
        check("b2b_no_idle", 64'(setup_hist[1] - setup_hist[0]), 64'd2);

        // Read with 3 wait states; strobes forced to zero
        en_hist.delete();
        expect_apb(2'b01, 4'h1, 32'h0000_00AA, 1'b0, 4'b0000, 3, 32'd15, 1'b0);
        expect_rsp(32'd15, 1'b0, 1'b0);
        send(1'b0, 4'h1, 32'h0000_00AA, 4'hF, pc);
        drain("read3");
        check("read3_penable_len", 64'(en_hist[0]), 64'd4);

        // Read answered with PSLVERR
        expect_apb(2'b10, 4'h9, 32'd0, 1'b0, 4'b0000, 0, 32'hDEAD_BEEF, 1'b1);
        expect_rsp(32'hDEAD_BEEF, 1'b1, 1'b0);
        send(1'b0, 4'h9, 32'd0, 4'h3, pc);
        drain("rd_err");

        // Timeout, then the queued write proceeds
        en_hist.delete();
        expect_apb(2'b01, 4'h1, 32'd0, 1'b0, 4'b0000, 1000, 32'h1234_5678, 1'b0);
        expect_apb(2'b10, 4'hE, 32'h55, 1'b1, 4'b1000, 0, 32'd0, 1'b0);
        expect_rsp(32'd0, 1'b1, 1'b1);
        expect_rsp(32'd0, 1'b0, 1'b0);
        send(1'b0, 4'h1, 32'd0, 4'h0, pc);
        send(1'b1, 4'hE, 32'h55, 4'b1000, pc2);
        drain("timeout");
        check("timeout_penable_len", 64'(en_hist[0]), 64'd16);
        check("after_timeout_penable_len", 64'(en_hist[1]), 64'd1);

        // FIFO fills while the first command stalls
        expect_apb(2'b10, 4'hF, 32'd1, 1'b1, 4'hF, 10, 32'd0, 1'b0);
        expect_apb(2'b01, 4'h1, 32'd2, 1'b1, 4'hF, 0, 32'd0, 1'b0);
        expect_apb(2'b10, 4'hF, 32'd3, 1'b1, 4'hF, 0, 32'd0, 1'b0);
        expect_apb(2'b01, 4'h1, 32'd4, 1'b1, 4'hF, 0, 32'd0, 1'b0);
        expect_apb(2'b10, 4'hF, 32'd5, 1'b1, 4'hF, 0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) expect_rsp(32'd0, 1'b0, 1'b0);
        send(1'b1, 4'hF, 32'd1, 4'hF, pc);
        send(1'b1, 4'h1, 32'd2, 4'hF, pc);
        send(1'b1, 4'hF, 32'd3, 4'hF, pc);
        send(1'b1, 4'h1, 32'd4, 4'hF, pc);
        send(1'b1, 4'hF, 32'd5, 4'hF, pc);
        @(negedge PCLK);
        check("full_level", 64'(FIFO_LEVEL), 64'd4);
        check("full_in_ready", 64'(IN_READY), 64'd0);
        drain("full");
        check("full_in_ready_after", 64'(IN_READY), 64'd1);

        // Reset in the middle of an ACCESS phase with another command queued
        expect_apb(2'b01, 4'h1, 32'd0, 1'b0, 4'b0000, 20, 32'h77, 1'b0);
        send(1'b0, 4'h1, 32'd0, 4'h0, pc);
        send(1'b1, 4'hF, 32'h99, 4'hF, pc);
        t = 0;
        while (!PENABLE && t < 50) begin
            @(negedge PCLK);
            t++;
        end
        check("reset_mid_reach_access", 64'(PENABLE), 64'd1);
        #1 PRESET = 1'b1;
        #1;
        check("mid_reset_psel", 64'(PSEL), 64'd0);
        check("mid_reset_penable", 64'(PENABLE), 64'd0);
        check("mid_reset_paddr", 64'(PADDR), 64'd0);
        check("mid_reset_out_valid", 64'(OUT_VALID), 64'd0);
        check("mid_reset_level", 64'(FIFO_LEVEL), 64'd0);
        check("mid_reset_in_ready", 64'(IN_READY), 64'd0);
        apb_q.delete();
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        check("after_reset_in_ready", 64'(IN_READY), 64'd1);
        setup_hist.delete();
        expect_apb(2'b10, 4'hF, 32'h3C, 1'b1, 4'b0011, 0, 32'd0, 1'b0);
        expect_rsp(32'd0, 1'b0, 1'b0);
        send(1'b1, 4'hF, 32'h3C, 4'b0011, pc);
        drain("after_reset");
        check("after_reset_setup_latency", 64'(setup_hist[0]), 64'(pc + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
